// File: rtl/boot_exit_ctrl.sv
// boot_exit_ctrl: waits for the config flash to go idle, then pulls ECP5
// PROGRAMN low for a fixed time to reconfigure into the user image. If the
// device survives, the pulse is retried periodically until reset. An exit
// can be requested by the bootloader (boot) or by a long button press.
module boot_exit_ctrl #(
    parameter int unsigned FLASH_IDLE_CYCLES     = 4800,
    parameter int unsigned PROGRAMN_PULSE_CYCLES = 480,
    parameter int unsigned RETRY_CYCLES          = 4800000,
    parameter int unsigned DEBOUNCE_CYCLES       = 65536,
    parameter int unsigned LONG_PRESS_CYCLES     = 96000000
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot,
    input  logic       flash_csn,
    input  logic       btn_exit,
    output logic       programn_drive_low,
    output logic       exit_pending,
    output logic       btn_debounced,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        PULSE     = 2'd2,
        DONE      = 2'd3
    } state_e;

    localparam int IDLE_W  = $clog2(FLASH_IDLE_CYCLES + 1);
    localparam int PULSE_W = $clog2(PROGRAMN_PULSE_CYCLES + 1);
    localparam int RETRY_W = $clog2(RETRY_CYCLES + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LP_W    = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(FLASH_IDLE_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PROGRAMN_PULSE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0]    LP_MAX     = LP_W'(LONG_PRESS_CYCLES);

    state_e             state_q, state_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [LP_W-1:0]    lp_cnt_q, lp_cnt_d;
    logic               btn_sync1_q, btn_sync1_d;
    logic               btn_sync2_q, btn_sync2_d;
    logic               btn_deb_q, btn_deb_d;
    logic               drive_low_q, drive_low_d;
    logic               exit_pending_q, exit_pending_d;
    logic               long_req;
    logic               exit_req;

    // Button path: 2-FF synchronizer, debounce and long-press detection.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        btn_sync1_d = btn_exit;
        btn_sync2_d = btn_sync1_q;
        btn_deb_d   = btn_deb_q;
        deb_cnt_d   = '0;
        lp_cnt_d    = '0;

        // Count only while the synchronized sample disagrees; any bounce
        // back to the debounced level restarts the count.
        if (btn_sync2_q != btn_deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_deb_d = ~btn_deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        // Saturate so a held button keeps requesting without wrapping.
        if (btn_deb_q) begin
            lp_cnt_d = (lp_cnt_q == LP_MAX) ? lp_cnt_q : lp_cnt_q + LP_W'(1);
        end
    end

    assign long_req = (lp_cnt_q == LP_MAX);
    assign exit_req = boot | long_req;

    // Exit sequencer: next state, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            IDLE: begin
                if (exit_req) begin
                    state_d    = WAIT_IDLE;
                    idle_cnt_d = '0;
                end
            end
            // The exit is committed here; only a busy flash delays it.
            WAIT_IDLE: begin
                if (!flash_csn) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d     = PULSE;
                    pulse_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d     = DONE;
                    retry_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                end
            end
            // Still alive after a pulse: re-check the flash and pulse again.
            DONE: begin
                if (retry_cnt_q == RETRY_LAST) begin
                    state_d    = WAIT_IDLE;
                    idle_cnt_d = '0;
                end else begin
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Drive comes straight from a flop so PROGRAMN never glitches; it
        // trails the PULSE state by one cycle but lasts exactly as long.
        drive_low_d    = (state_q == PULSE);
        exit_pending_d = (state_d != IDLE);
    end

    // All state registers with synchronous reset; reset releases PROGRAMN at once.
    always_ff @(posedge clk_48mhz) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q        <= IDLE;
            idle_cnt_q     <= '0;
            pulse_cnt_q    <= '0;
            retry_cnt_q    <= '0;
            deb_cnt_q      <= '0;
            lp_cnt_q       <= '0;
            btn_sync1_q    <= 1'b0;
            btn_sync2_q    <= 1'b0;
            btn_deb_q      <= 1'b0;
            drive_low_q    <= 1'b0;
            exit_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idle_cnt_q     <= idle_cnt_d;
            pulse_cnt_q    <= pulse_cnt_d;
            retry_cnt_q    <= retry_cnt_d;
            deb_cnt_q      <= deb_cnt_d;
            lp_cnt_q       <= lp_cnt_d;
            btn_sync1_q    <= btn_sync1_d;
            btn_sync2_q    <= btn_sync2_d;
            btn_deb_q      <= btn_deb_d;
            drive_low_q    <= drive_low_d;
            exit_pending_q <= exit_pending_d;
        end
    end

    assign programn_drive_low = drive_low_q;
    assign exit_pending       = exit_pending_q;
    assign btn_debounced      = btn_deb_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_boot_exit_ctrl.sv
// Directed bench for boot_exit_ctrl with shortened timing parameters.
module tb_boot_exit_ctrl;

    localparam int F = 16;  // flash idle cycles
    localparam int P = 8;   // PROGRAMN pulse cycles
    localparam int R = 32;  // retry cycles
    localparam int D = 8;   // debounce cycles
    localparam int L = 20;  // long-press cycles

    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b1;
    logic       boot      = 1'b0;
    logic       flash_csn = 1'b1;
    logic       btn_exit  = 1'b0;
    logic       programn_drive_low;
    logic       exit_pending;
    logic       btn_debounced;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    boot_exit_ctrl #(
        .FLASH_IDLE_CYCLES    (F),
        .PROGRAMN_PULSE_CYCLES(P),
        .RETRY_CYCLES         (R),
        .DEBOUNCE_CYCLES      (D),
        .LONG_PRESS_CYCLES    (L)
    ) dut (
        .clk_48mhz         (clk_48mhz),
        .reset             (reset),
        .boot              (boot),
        .flash_csn         (flash_csn),
        .btn_exit          (btn_exit),
        .programn_drive_low(programn_drive_low),
        .exit_pending      (exit_pending),
        .btn_debounced     (btn_debounced),
        .state_dbg         (state_dbg)
    );

    // 48 MHz-ish clock; the exact period does not matter to the design.
    always #5 clk_48mhz = ~clk_48mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        boot      = 1'b0;
        flash_csn = 1'b1;
        btn_exit  = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Edge 0 is the edge that entered WAIT_IDLE; drive_low is expected high
    // for edges t_pulse .. t_pulse+P-1, PULSE state one edge earlier.
    task automatic track(input string tag, input int t_pulse, input int n);
        logic [31:0] exp_drive;
        logic [31:0] exp_state;
        for (int i = 1; i <= n; i++) begin
            tick();
            exp_drive = (i >= t_pulse && i < t_pulse + P) ? 32'd1 : 32'd0;
            exp_state = (i < t_pulse - 1) ? 32'd1 : (i < t_pulse - 1 + P) ? 32'd2 : 32'd3;
            check($sformatf("%s_drive@%0d", tag, i), 32'(programn_drive_low), exp_drive);
            check($sformatf("%s_state@%0d", tag, i), 32'(state_dbg), exp_state);
            check($sformatf("%s_pend@%0d", tag, i), 32'(exit_pending), 32'd1);
        end
    endtask

    initial begin
        // Reset values.
        reset = 1'b1;
        btn_exit = 1'b1;
        tick();
        tick();
        tick();
        check("rst_drive", 32'(programn_drive_low), 32'd0);
        check("rst_pend", 32'(exit_pending), 32'd0);
        check("rst_deb", 32'(btn_debounced), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        btn_exit = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("idle_state", 32'(state_dbg), 32'd0);
        check("idle_pend", 32'(exit_pending), 32'd0);

        // Boot request with flash idle: pulse after F+1 edges, P cycles long.
        boot = 1'b1;
        tick();
        check("t1_enter_state", 32'(state_dbg), 32'd1);
        check("t1_enter_pend", 32'(exit_pending), 32'd1);
        track("t1", F + 1, F + P + 2);

        // Stay in DONE for R cycles, then a second WAIT_IDLE and pulse.
        for (int i = F + P + 3; i <= F + P + R - 1; i++) begin
            tick();
            check($sformatf("done_state@%0d", i), 32'(state_dbg), 32'd3);
            check($sformatf("done_drive@%0d", i), 32'(programn_drive_low), 32'd0);
            check($sformatf("done_pend@%0d", i), 32'(exit_pending), 32'd1);
        end
        tick();
        check("retry_enter_state", 32'(state_dbg), 32'd1);
        track("retry", F + 1, F + P + 2);

        // Reset during the fourth PULSE cycle releases PROGRAMN immediately.
        do_reset();
        boot = 1'b1;
        tick();
        for (int i = 1; i <= F + 3; i++) tick();
        check("mid_pulse_state", 32'(state_dbg), 32'd2);
        check("mid_pulse_drive", 32'(programn_drive_low), 32'd1);
        reset = 1'b1;
        tick();
        check("rstp_drive", 32'(programn_drive_low), 32'd0);
        check("rstp_state", 32'(state_dbg), 32'd0);
        check("rstp_pend", 32'(exit_pending), 32'd0);
        reset = 1'b0;
        tick();
        check("restart_enter_state", 32'(state_dbg), 32'd1);
        track("restart", F + 1, F + P + 2);

        // boot drops one cycle into WAIT_IDLE: the exit still completes.
        do_reset();
        boot = 1'b1;
        tick();
        tick();
        boot = 1'b0;
        track("commit", F, F + P + 1);

        // One-cycle flash select at cycle 10 of WAIT_IDLE restarts the idle count.
        do_reset();
        boot = 1'b1;
        tick();
        boot = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("glitch_pre_state@%0d", i), 32'(state_dbg), 32'd1);
            check($sformatf("glitch_pre_drive@%0d", i), 32'(programn_drive_low), 32'd0);
        end
        flash_csn = 1'b0;
        tick();
        check("glitch_csn_state", 32'(state_dbg), 32'd1);
        flash_csn = 1'b1;
        track("glitch", F + 1, F + P + 2);

        // Flash held selected: never pulse.
        do_reset();
        flash_csn = 1'b0;
        boot = 1'b1;
        tick();
        for (int i = 1; i <= 60; i++) begin
            tick();
            check($sformatf("busy_drive@%0d", i), 32'(programn_drive_low), 32'd0);
            check($sformatf("busy_state@%0d", i), 32'(state_dbg), 32'd1);
        end

        // Bouncy button: 5 high / 2 low never reaches the debounce threshold.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            btn_exit = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                check($sformatf("bounce_deb_%0d_h%0d", b, i), 32'(btn_debounced), 32'd0);
                check($sformatf("bounce_state_%0d_h%0d", b, i), 32'(state_dbg), 32'd0);
            end
            btn_exit = 1'b0;
            for (int i = 0; i < 2; i++) begin
                tick();
                check($sformatf("bounce_deb_%0d_l%0d", b, i), 32'(btn_debounced), 32'd0);
            end
        end

        // Held button: debounced after 2+8 edges, exit L+1 edges later.
        btn_exit = 1'b1;
        for (int i = 1; i <= 2 + D + L + 1; i++) begin
            tick();
            check($sformatf("hold_deb@%0d", i), 32'(btn_debounced), (i >= 2 + D) ? 32'd1 : 32'd0);
            check($sformatf("hold_state@%0d", i), 32'(state_dbg), (i >= 2 + D + L + 1) ? 32'd1 : 32'd0);
        end
        track("btn", F + 1, F + P + 2);

        // Release: debounced level falls after the same 2+8 edges.
        btn_exit = 1'b0;
        for (int i = 1; i <= 2 + D + 2; i++) begin
            tick();
            check($sformatf("release_deb@%0d", i), 32'(btn_debounced), (i < 2 + D) ? 32'd1 : 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_exit_ctrl.md
Name: boot_exit_ctrl

Overview:
Sits downstream of the SPI bootloader core in the ULX3S top level. It consumes the bootloader's `boot` request and a user exit button, and drives the ECP5 PROGRAMN pin low to trigger reconfiguration into the user image. Before pulsing, it waits until the config flash has been deselected and idle for a programmable time, so a reconfiguration never cuts off an in-flight flash transaction. If the device is still alive after a pulse, it re-pulses periodically until reset.

Parameters:
FLASH_IDLE_CYCLES, 4800, consecutive clk cycles with flash_csn=1 required before the pulse (100 us at 48 MHz).
PROGRAMN_PULSE_CYCLES, 480, cycles PROGRAMN is held low per pulse (10 us).
RETRY_CYCLES, 4800000, cycles spent in DONE before re-pulsing (100 ms).
DEBOUNCE_CYCLES, 65536, consecutive equal synchronized samples required to change the debounced button level.
LONG_PRESS_CYCLES, 96000000, cycles the debounced button must stay high to request exit (2 s).

Ports:
clk_48mhz  input  1  system clock, 48 MHz
reset  input  1  synchronous, active-high reset
boot  input  1  exit request level from the bootloader core, same clock domain
flash_csn  input  1  config flash chip select as driven by the bootloader (1 = deselected), same domain
btn_exit  input  1  raw asynchronous button, active-high
programn_drive_low  output  1  1 = top level drives user_programn to 0; 0 = hi-Z
exit_pending  output  1  high in every state except IDLE
btn_debounced  output  1  debounced button level
state_dbg  output  2  current state encoding: IDLE=0, WAIT_IDLE=1, PULSE=2, DONE=3

Behaviour:
- Reset and clocking (already decided): one clock, clk_48mhz; reset is synchronous and active-high.
- Reset values: programn_drive_low=0, exit_pending=0, btn_debounced=0, state=IDLE, all counters=0, button synchronizer flops=0.
- Reset mid-operation: all outputs take their reset values at the first clock edge with reset=1, including mid-pulse, so PROGRAMN is released within one cycle.
- Button synchronization: btn_exit passes through a 2-FF synchronizer.
- Debounce counter:
  - Increments while the synchronized sample differs from btn_debounced; clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a sample still differing, btn_debounced toggles on that edge and the counter clears.
  - Any bounce back to the debounced level restarts the count.
- Long-press counter:
  - Increments while btn_debounced=1 and saturates at LONG_PRESS_CYCLES.
  - Clears when btn_debounced=0.
  - long_req = (counter == LONG_PRESS_CYCLES), a level.
- Exit request: exit_req = boot | long_req, sampled only in IDLE.
- IDLE: if exit_req, go to WAIT_IDLE and clear idle_cnt.
- WAIT_IDLE:
  - If flash_csn=0, idle_cnt clears.
  - Otherwise idle_cnt increments.
  - When idle_cnt == FLASH_IDLE_CYCLES-1 and flash_csn=1, go to PULSE and clear pulse_cnt.
  - Net effect: with boot first sampled high at edge k and flash_csn=1 throughout, programn_drive_low first reads 1 after edge k+1+FLASH_IDLE_CYCLES.
  - exit_req deasserting in WAIT_IDLE does not abort; the exit is committed.
- PULSE:
  - programn_drive_low=1 (registered, glitch-free).
  - pulse_cnt increments each cycle; at PROGRAMN_PULSE_CYCLES-1 go to DONE.
  - Net effect: drive_low is high for exactly PROGRAMN_PULSE_CYCLES cycles.
  - flash_csn is ignored during PULSE.
- DONE:
  - programn_drive_low=0 and retry_cnt increments.
  - At RETRY_CYCLES-1 go to WAIT_IDLE (the flash idle check is re-run before every retry pulse).
  - Only reset returns the block to IDLE.
- Simultaneous events:
  - boot and long_req together count as a single request.
  - A button press or boot change outside IDLE is ignored; debounce and long-press counters keep running.
- Counter widths: each counter is wide enough for its parameter (ceil log2); none wraps, all saturate or clear as stated.
- exit_pending = (state != IDLE), registered together with the state.

Test Plan:
- Parameters FLASH_IDLE_CYCLES=16, PROGRAMN_PULSE_CYCLES=8, RETRY_CYCLES=32. Set boot=1 at edge k with flash_csn=1 -> programn_drive_low first high after edge k+17, high for exactly 8 cycles; state_dbg sequence 0,1,2,3.
- Same setup, flash_csn pulsed low for 1 cycle at cycle 10 of WAIT_IDLE -> idle count restarts; pulse begins 16 cycles after csn returns high. Hold csn=0 -> no pulse ever.
- DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=20, boot=0. btn_exit bursts of 5 cycles high/2 low -> btn_debounced stays 0, no exit. Then hold high -> btn_debounced=1 after 2+8 cycles; state leaves IDLE 20 cycles later.
- After the first pulse, stay in DONE for 32 cycles -> second WAIT_IDLE and second 8-cycle pulse follow; exit_pending stays 1 throughout.
- Assert reset during cycle 4 of PULSE -> programn_drive_low=0, state_dbg=0, exit_pending=0 at the next edge. With boot still 1 after reset releases -> the full sequence restarts with exact latency.
- Deassert boot one cycle after entering WAIT_IDLE -> the pulse still occurs (committed exit).
